// File: rtl/spi_reg_arbiter.sv
// Arbitrates SPI-slave and local register requests onto a single register-file bus,
// alternating on contention and timing out stalled bus cycles.
module spi_reg_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_start_flag,
    input  logic              spi_addr_valid,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic              spi_rw,
    input  logic [DATA_W-1:0] spi_wdata,
    input  logic              spi_wdata_valid,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_rd_en,
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic              loc_rvalid,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              tmo_err
);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t            state;
    logic              addr_valid_q;
    logic              wdata_valid_q;
    logic              rd_pend;
    logic              wr_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              last_spi;
    logic              win_spi;
    logic [7:0]        wait_cnt;

    logic              rd_rise;
    logic              wr_rise;
    logic              spi_any;
    logic              pick_loc;
    logic              bus_end;
    logic [DATA_W-1:0] rsp_data;

    // A write edge coinciding with a read edge is a protocol error; the read wins.
    assign rd_rise  = spi_addr_valid & ~addr_valid_q & spi_rw;
    assign wr_rise  = spi_wdata_valid & ~wdata_valid_q & ~spi_rw & ~rd_rise;
    assign spi_any  = rd_pend | wr_pend;
    assign pick_loc = loc_req & (last_spi | ~spi_any);
    assign bus_end  = bus_ack | (wait_cnt >= TMO_LAST);
    assign rsp_data = bus_ack ? bus_rdata : {DATA_W{1'b1}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr_valid_q  <= 1'b0;
            wdata_valid_q <= 1'b0;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            rd_addr       <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            last_spi      <= 1'b0;
            win_spi       <= 1'b0;
            wait_cnt      <= '0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            spi_rdata     <= '0;
            spi_rd_en     <= 1'b0;
            loc_gnt       <= 1'b0;
            loc_rvalid    <= 1'b0;
            loc_rdata     <= '0;
            tmo_err       <= 1'b0;
        end else begin
            addr_valid_q  <= spi_addr_valid;
            wdata_valid_q <= spi_wdata_valid;
            loc_gnt       <= 1'b0;
            loc_rvalid    <= 1'b0;
            tmo_err       <= 1'b0;

            // A new SPI transaction discards anything not yet granted.
            if (spi_start_flag) begin
                rd_pend   <= 1'b0;
                wr_pend   <= 1'b0;
                spi_rd_en <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (loc_req || spi_any) begin
                        state    <= GRANT;
                        wait_cnt <= '0;
                        if (pick_loc) begin
                            last_spi  <= 1'b0;
                            win_spi   <= 1'b0;
                            loc_gnt   <= 1'b1;
                            bus_we    <= loc_we;
                            bus_addr  <= loc_addr;
                            bus_wdata <= loc_wdata;
                        end else if (rd_pend) begin
                            last_spi <= 1'b1;
                            win_spi  <= 1'b1;
                            rd_pend  <= 1'b0;
                            bus_we   <= 1'b0;
                            bus_addr <= rd_addr;
                        end else begin
                            last_spi  <= 1'b1;
                            win_spi   <= 1'b1;
                            wr_pend   <= 1'b0;
                            bus_we    <= 1'b1;
                            bus_addr  <= wr_addr;
                            bus_wdata <= wr_data;
                        end
                    end
                end
                GRANT: begin
                    bus_req <= 1'b1;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus_end) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        tmo_err <= ~bus_ack;
                        if (win_spi) begin
                            if (!bus_we) begin
                                spi_rdata <= rsp_data;
                                spi_rd_en <= 1'b1;
                            end
                        end else begin
                            loc_rvalid <= 1'b1;
                            if (!bus_we) begin
                                loc_rdata <= rsp_data;
                            end
                        end
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Captures come last so an edge arriving alongside a grant or start is kept.
            if (rd_rise) begin
                rd_pend <= 1'b1;
                rd_addr <= spi_addr;
            end
            if (wr_rise) begin
                wr_pend <= 1'b1;
                wr_addr <= spi_addr;
                wr_data <= spi_wdata;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Scoreboard bench for spi_reg_arbiter: expected bus cycles and read results are queued
// as stimulus is driven and checked as the DUT produces them.
module tb_spi_reg_arbiter;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int TMO_CYC = 8;
    localparam int OUT_W   = 3 * DATA_W + ADDR_W + 6;
    localparam logic [7:0] RF_KEY = 8'hB7;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_txn_t;

    logic              clk;
    logic              reset_n;
    logic              spi_start_flag;
    logic              spi_addr_valid;
    logic [ADDR_W-1:0] spi_addr;
    logic              spi_rw;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_wdata_valid;
    logic [DATA_W-1:0] spi_rdata;
    logic              spi_rd_en;
    logic              loc_req;
    logic              loc_we;
    logic [ADDR_W-1:0] loc_addr;
    logic [DATA_W-1:0] loc_wdata;
    logic              loc_gnt;
    logic              loc_rvalid;
    logic [DATA_W-1:0] loc_rdata;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              tmo_err;

    logic ack_en;
    logic ack_force;

    bus_txn_t    exp_bus[$];
    logic [7:0]  exp_spi[$];
    logic [7:0]  exp_loc[$];
    int          vectors;
    int          miscompares;
    logic        prev_req;
    logic        prev_rd_en;

    spi_reg_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi_start_flag (spi_start_flag),
        .spi_addr_valid (spi_addr_valid),
        .spi_addr       (spi_addr),
        .spi_rw         (spi_rw),
        .spi_wdata      (spi_wdata),
        .spi_wdata_valid(spi_wdata_valid),
        .spi_rdata      (spi_rdata),
        .spi_rd_en      (spi_rd_en),
        .loc_req        (loc_req),
        .loc_we         (loc_we),
        .loc_addr       (loc_addr),
        .loc_wdata      (loc_wdata),
        .loc_gnt        (loc_gnt),
        .loc_rvalid     (loc_rvalid),
        .loc_rdata      (loc_rdata),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .tmo_err        (tmo_err)
    );

    // Register-file model: acks in the first WAIT_ACK cycle when enabled, data keyed on address.
    assign bus_ack   = ack_force | (ack_en & bus_req);
    assign bus_rdata = {1'b0, bus_addr} ^ RF_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rf(input logic [ADDR_W-1:0] a);
        return {1'b0, a} ^ RF_KEY;
    endfunction

    function automatic bus_txn_t mk(input logic we, input logic [ADDR_W-1:0] a,
                                    input logic [DATA_W-1:0] d);
        bus_txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        return t;
    endfunction

    function automatic logic [OUT_W-1:0] all_outputs();
        return {bus_req, bus_we, bus_addr, bus_wdata, spi_rdata, spi_rd_en,
                loc_gnt, loc_rvalid, loc_rdata, tmo_err};
    endfunction

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return bus_req;
            1:       return spi_rd_en;
            default: return loc_rvalid;
        endcase
    endfunction

    // One clock; the local requester drops its request on grant and the scoreboard is serviced.
    task automatic step();
        bus_txn_t t;
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (loc_gnt) loc_req = 1'b0;
        if (bus_req && !prev_req) begin
            vectors++;
            if (exp_bus.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_bus_cycle: got we=%0b addr=%h wdata=%h, required none",
                         bus_we, bus_addr, bus_wdata);
            end else begin
                t = exp_bus.pop_front();
                if (bus_we !== t.we || bus_addr !== t.addr || (t.we && bus_wdata !== t.wdata)) begin
                    miscompares++;
                    $display("[TB] FAIL bus_txn: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                             bus_we, bus_addr, bus_wdata, t.we, t.addr, t.wdata);
                end
            end
        end
        if (spi_rd_en && !prev_rd_en) begin
            vectors++;
            if (exp_spi.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_spi_rd_en: got rdata=%h, required none", spi_rdata);
            end else begin
                e = exp_spi.pop_front();
                if (spi_rdata !== e) begin
                    miscompares++;
                    $display("[TB] FAIL spi_rdata: got %h, required %h", spi_rdata, e);
                end
            end
        end
        if (loc_rvalid) begin
            vectors++;
            if (exp_loc.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_loc_rvalid: got rdata=%h, required none", loc_rdata);
            end else begin
                e = exp_loc.pop_front();
                if (loc_rdata !== e) begin
                    miscompares++;
                    $display("[TB] FAIL loc_rdata: got %h, required %h", loc_rdata, e);
                end
            end
        end
        prev_req   = bus_req;
        prev_rd_en = spi_rd_en;
    endtask

    task automatic wait_sig(input int sel, input string name);
        int n;
        n = 0;
        while (!sig_of(sel) && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (!sig_of(sel)) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: got 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic spi_start();
        spi_start_flag = 1'b1;
        step();
        spi_start_flag = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if ({bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got %b, required 0", {bus_req, bus_we, bus_addr, bus_wdata});
        end
        if ({spi_rdata, spi_rd_en} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_spi: got %h, required 0", {spi_rdata, spi_rd_en});
        end
        if ({loc_gnt, loc_rvalid, loc_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_loc: got %h, required 0", {loc_gnt, loc_rvalid, loc_rdata});
        end
        if (tmo_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_tmo: got %b, required 0", tmo_err);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_alternation();
        ack_en = 1'b1;
        spi_start();
        exp_bus.push_back(mk(1'b0, 7'h21, 8'h00));
        exp_bus.push_back(mk(1'b0, 7'h40, 8'h00));
        exp_bus.push_back(mk(1'b0, 7'h22, 8'h00));
        exp_bus.push_back(mk(1'b0, 7'h41, 8'h00));
        exp_bus.push_back(mk(1'b0, 7'h23, 8'h00));
        exp_spi.push_back(rf(7'h21));
        exp_spi.push_back(rf(7'h22));
        exp_spi.push_back(rf(7'h23));
        exp_loc.push_back(rf(7'h40));
        exp_loc.push_back(rf(7'h41));
        spi_rw = 1'b1;
        spi_addr = 7'h21;
        spi_addr_valid = 1'b1;
        step();
        loc_we = 1'b0;
        loc_addr = 7'h40;
        loc_req = 1'b1;
        wait_sig(1, "alt_spi21");
        spi_addr_valid = 1'b0;
        spi_start();
        spi_addr = 7'h22;
        spi_addr_valid = 1'b1;
        wait_sig(1, "alt_spi22");
        spi_addr_valid = 1'b0;
        loc_addr = 7'h41;
        loc_req = 1'b1;
        spi_start();
        spi_addr = 7'h23;
        spi_addr_valid = 1'b1;
        wait_sig(1, "alt_spi23");
        spi_addr_valid = 1'b0;
        repeat (6) step();
        vectors++;
        if (exp_bus.size() + exp_loc.size() + exp_spi.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL alt_outstanding: got %0d bus/%0d loc/%0d spi left, required 0",
                     exp_bus.size(), exp_loc.size(), exp_spi.size());
        end
    endtask

    task automatic test_spi_read();
        int n;
        ack_en = 1'b1;
        spi_start();
        exp_bus.push_back(mk(1'b0, 7'h12, 8'h00));
        exp_spi.push_back(8'hA5);
        spi_rw = 1'b1;
        spi_addr = 7'h12;
        spi_addr_valid = 1'b1;
        n = 0;
        while (!spi_rd_en && n < 10) begin
            step();
            n++;
        end
        vectors++;
        if (!spi_rd_en || n > 4) begin
            miscompares++;
            $display("[TB] FAIL read_latency: got rd_en=%0b after %0d clk, required 1 within 4", spi_rd_en, n);
        end
        spi_addr_valid = 1'b0;
        step();
        vectors++;
        if (spi_rd_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rd_en_hold: got %b, required 1", spi_rd_en);
        end
        spi_start();
        vectors++;
        if (spi_rd_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_en_clear: got %b, required 0", spi_rd_en);
        end
    endtask

    task automatic test_spi_write();
        spi_start();
        exp_bus.push_back(mk(1'b1, 7'h05, 8'h3C));
        spi_rw = 1'b0;
        spi_addr = 7'h05;
        spi_addr_valid = 1'b1;
        step();
        spi_wdata = 8'h3C;
        spi_wdata_valid = 1'b1;
        repeat (8) step();
        vectors += 2;
        if (exp_bus.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL write_cycle: got %0d pending, required 0", exp_bus.size());
        end
        if (spi_rd_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_no_rd_en: got %b, required 0", spi_rd_en);
        end
        spi_wdata_valid = 1'b0;
        spi_addr_valid = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_simultaneous();
        spi_start();
        exp_bus.push_back(mk(1'b0, 7'h15, 8'h00));
        exp_spi.push_back(rf(7'h15));
        spi_rw = 1'b1;
        spi_addr = 7'h15;
        spi_wdata = 8'h77;
        spi_addr_valid = 1'b1;
        spi_wdata_valid = 1'b1;
        wait_sig(1, "simul_read");
        spi_addr_valid = 1'b0;
        spi_wdata_valid = 1'b0;
        repeat (6) step();
        vectors++;
        if (exp_bus.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL simul_outstanding: got %0d pending, required 0", exp_bus.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        ack_en = 1'b0;
        spi_start();
        exp_bus.push_back(mk(1'b0, 7'h30, 8'h00));
        exp_spi.push_back(8'hFF);
        spi_rw = 1'b1;
        spi_addr = 7'h30;
        spi_addr_valid = 1'b1;
        wait_sig(0, "tmo_bus_req");
        n = 0;
        while (bus_req && n < 20) begin
            n++;
            step();
        end
        vectors += 4;
        if (n != TMO_CYC) begin
            miscompares++;
            $display("[TB] FAIL tmo_wait_cycles: got %0d, required %0d", n, TMO_CYC);
        end
        if (tmo_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tmo_err_pulse: got %b, required 1", tmo_err);
        end
        step();
        if (tmo_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tmo_err_width: got %b, required 0", tmo_err);
        end
        if (spi_rd_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tmo_rd_en: got %b, required 1", spi_rd_en);
        end
        spi_addr_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_ack_outside();
        int seen;
        spi_start();
        ack_force = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (bus_req || spi_rd_en || loc_rvalid || tmo_err) seen++;
        end
        ack_force = 1'b0;
        vectors += 2;
        if (seen != 0) begin
            miscompares++;
            $display("[TB] FAIL stray_ack: got %0d active cycles, required 0", seen);
        end
        if (spi_rdata !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL stray_ack_rdata: got %h, required ff", spi_rdata);
        end
    endtask

    task automatic test_start_drop();
        ack_en = 1'b0;
        exp_bus.push_back(mk(1'b1, 7'h60, 8'h11));
        // A local write leaves loc_rdata at the last local read result (address 0x41).
        exp_loc.push_back(rf(7'h41));
        loc_we = 1'b1;
        loc_addr = 7'h60;
        loc_wdata = 8'h11;
        loc_req = 1'b1;
        wait_sig(0, "drop_bus_req");
        spi_rw = 1'b1;
        spi_addr = 7'h70;
        spi_addr_valid = 1'b1;
        step();
        step();
        spi_start();
        ack_en = 1'b1;
        wait_sig(2, "drop_loc_rvalid");
        repeat (8) step();
        vectors += 3;
        if (exp_bus.size() != 0 || exp_loc.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drop_outstanding: got %0d bus/%0d loc, required 0",
                     exp_bus.size(), exp_loc.size());
        end
        if (spi_rd_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_rd_en: got %b, required 0", spi_rd_en);
        end
        if (tmo_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_tmo: got %b, required 0", tmo_err);
        end
        spi_addr_valid = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        int seen;
        ack_en = 1'b0;
        exp_bus.push_back(mk(1'b0, 7'h50, 8'h00));
        loc_we = 1'b0;
        loc_addr = 7'h50;
        loc_req = 1'b1;
        wait_sig(0, "rst_bus_req");
        step();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs: got %h, required 0", all_outputs());
        end
        repeat (2) step();
        vectors++;
        if (all_outputs() !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_held: got %h, required 0", all_outputs());
        end
        reset_n = 1'b1;
        ack_en = 1'b1;
        seen = 0;
        repeat (12) begin
            step();
            if (bus_req || spi_rd_en || loc_rvalid || tmo_err) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_pulses: got %0d active cycles, required 0", seen);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        prev_req = 1'b0;
        prev_rd_en = 1'b0;
        reset_n = 1'b0;
        ack_en = 1'b0;
        ack_force = 1'b0;
        spi_start_flag = 1'b0;
        spi_addr_valid = 1'b0;
        spi_addr = '0;
        spi_rw = 1'b0;
        spi_wdata = '0;
        spi_wdata_valid = 1'b0;
        loc_req = 1'b0;
        loc_we = 1'b0;
        loc_addr = '0;
        loc_wdata = '0;

        $display("[TB] starting spi_reg_arbiter bench");
        test_reset();
        test_alternation();
        test_spi_read();
        test_spi_write();
        test_simultaneous();
        test_timeout();
        test_ack_outside();
        test_start_drop();
        test_reset_mid();

        vectors++;
        if (exp_bus.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL final_outstanding: got %0d bus cycles, required 0", exp_bus.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width.
REQ-002 SHALL have parameter DATA_W, default 8, register data width.
REQ-003 SHALL have parameter TMO_CYC, default 64, bus-ack timeout in clk cycles (2..255).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port spi_start_flag  input  1  one-cycle pulse at SPI transaction start.
REQ-007 SHALL have port spi_addr_valid  input  1  level, high once SPI address is captured.
REQ-008 SHALL have port spi_addr  input  ADDR_W  SPI register address.
REQ-009 SHALL have port spi_rw  input  1  1 = SPI read, 0 = SPI write.
REQ-010 SHALL have port spi_wdata  input  DATA_W  SPI write data.
REQ-011 SHALL have port spi_wdata_valid  input  1  level, high once SPI write data is complete.
REQ-012 SHALL have port spi_rdata  output  DATA_W  read data returned to the SPI slave.
REQ-013 SHALL have port spi_rd_en  output  1  spi_rdata valid.
REQ-014 SHALL have ports loc_req/loc_we  input  1  local requester request and write enable.
REQ-015 SHALL have ports loc_addr ADDR_W and loc_wdata DATA_W  input  local address and write data.
REQ-016 SHALL have ports loc_gnt  output  1  and loc_rvalid  output  1, both one-cycle pulses; loc_rdata  output  DATA_W.
REQ-017 SHALL have ports bus_req, bus_we  output  1; bus_addr ADDR_W and bus_wdata DATA_W  output.
REQ-018 SHALL have ports bus_ack  input  1  and bus_rdata  input  DATA_W  (register file response).
REQ-019 SHALL have port tmo_err  output  1  one-cycle pulse on bus timeout.

Function
- Request capture
REQ-020 SHALL detect the rising edge of spi_addr_valid with spi_rw=1 and set an SPI-read pending flag, latching spi_addr.
REQ-021 SHALL detect the rising edge of spi_wdata_valid with spi_rw=0 and set an SPI-write pending flag, latching spi_addr and spi_wdata.
REQ-022 SHALL treat local requests as valid while loc_req=1; the requester holds loc_* stable until loc_gnt.
- FSM: IDLE, GRANT, WAIT_ACK, DONE.
REQ-023 SHALL move IDLE->GRANT when any request is pending; the winner is latched in GRANT.
REQ-024 SHALL arbitrate with SPI priority, except when the previous grant was SPI and loc_req is high, the local request wins (alternating on contention).
REQ-025 SHALL pulse loc_gnt in GRANT cycle for a local winner.
REQ-026 SHALL in WAIT_ACK hold bus_req=1 with bus_addr/bus_we/bus_wdata stable until bus_ack=1 or timeout.
REQ-027 SHALL on bus_ack move to DONE, deassert bus_req in the same cycle as the transition, and return to IDLE one cycle later.
REQ-028 SHALL for an SPI read, latch bus_rdata into spi_rdata and set spi_rd_en=1 at DONE entry; spi_rd_en holds until the next spi_start_flag.
REQ-029 SHALL for a local read, drive loc_rdata=bus_rdata and pulse loc_rvalid at DONE entry; local writes pulse loc_rvalid with loc_rdata unchanged.
REQ-030 SHALL complete an SPI read within 4 clk from spi_addr_valid rise when the bus is idle and bus_ack arrives in the first WAIT_ACK cycle.
REQ-031 SHALL count WAIT_ACK cycles with a saturating 8-bit counter; at TMO_CYC it pulses tmo_err, drops bus_req and enters DONE.
REQ-032 SHALL on timeout return all-ones data (spi_rdata or loc_rdata) for reads and discard writes.
- Boundaries
REQ-033 SHALL on spi_start_flag clear spi_rd_en and any SPI pending flag not yet granted; an in-flight bus cycle completes normally.
REQ-034 SHALL on simultaneous SPI-read and SPI-write edges (protocol error) service only the read.
REQ-035 SHALL ignore bus_ack outside WAIT_ACK.
REQ-036 SHALL never issue a new bus_req in the cycle bus_req falls (minimum one idle cycle).

Reset
REQ-037 SHALL while reset_n=0 force FSM=IDLE, pending flags=0, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, spi_rdata=0, spi_rd_en=0, loc_gnt=0, loc_rvalid=0, loc_rdata=0, tmo_err=0.
REQ-038 SHALL on reset assertion mid-transaction abandon it with no output pulse after reset release.

Verification
REQ-039 SPI read addr 0x12, bus_ack next cycle with rdata 0xA5 -> spi_rdata=0xA5, spi_rd_en=1 within 4 clk, cleared by next spi_start_flag.
REQ-040 SPI write addr 0x05 data 0x3C -> exactly one bus cycle bus_we=1, addr 0x05, wdata 0x3C.
REQ-041 loc_req held with continuous SPI traffic -> grants alternate SPI, local, SPI; local never starved.
REQ-042 bus_ack held low, TMO_CYC=8, SPI read -> tmo_err pulse after 8 WAIT_ACK cycles, spi_rdata=0xFF.
REQ-043 reset_n pulsed low during WAIT_ACK -> all outputs zero, no loc_rvalid/spi_rd_en after release.
REQ-044 spi_start_flag while SPI read pending and local cycle in flight -> local completes, SPI read dropped, no bus cycle for it.
